// File: rtl/hazard_pkg.sv
// Shared encodings for the scoreboard hazard unit: forward-select codes and
// the PC register index, which never takes part in scoreboard tracking.
package hazard_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

    localparam int unsigned PC_REG = 15;

    // M-stage match beats W-stage match, matching the legacy forwarding unit.
    function automatic fwd_sel_t fwd_select(input logic hit_m, input logic hit_w);
        if (hit_m)
            return FWD_M;
        else if (hit_w)
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_sb_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, wrapping around. The pointer register belongs to the caller.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o
);

    int   idx;
    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr_i) + i) % N;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_sb.sv
// Scoreboard hazard unit for the 5-stage pipeline: forwarding, load-use stall,
// branch flush, and tracking of registers owned by multi-cycle units.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int RA_W     = 4,
    parameter int NUM_REGS = 16,
    parameter int NUM_MC   = 2,
    parameter int CNT_W    = 32
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [RA_W-1:0]     RA1D,
    input  logic [RA_W-1:0]     RA2D,
    input  logic [RA_W-1:0]     WA3D,
    input  logic                RegWriteD,
    input  logic [RA_W-1:0]     RA1E,
    input  logic [RA_W-1:0]     RA2E,
    input  logic [RA_W-1:0]     WA3E,
    input  logic                RegWriteE,
    input  logic                MemtoRegE,
    input  logic                PCSrcE,
    input  logic [NUM_MC-1:0]   Start_MC_E,
    input  logic [NUM_MC-1:0]   Done_MC,
    input  logic [RA_W-1:0]     WA3M,
    input  logic [RA_W-1:0]     RA2M,
    input  logic                RegWriteM,
    input  logic                MemWriteM,
    input  logic [RA_W-1:0]     WA3W,
    input  logic                RegWriteW,
    input  logic                MemtoRegW,
    output logic                StallF,
    output logic                StallD,
    output logic                FlushD,
    output logic                FlushE,
    output logic                FlushM,
    output logic [1:0]          ForwardAE,
    output logic [1:0]          ForwardBE,
    output logic                ForwardM,
    output logic [NUM_MC-1:0]   WB_Grant,
    output logic [NUM_MC-1:0]   Busy_MC,
    output logic [NUM_REGS-1:0] Pending,
    output logic [CNT_W-1:0]    StallCount
);

    localparam int RR_W = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;
    localparam logic [RA_W-1:0] PC_ADDR = RA_W'(PC_REG);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_MC-1:0]   busy_q, busy_d;
    logic [RA_W-1:0]     dest_q [NUM_MC];
    logic [RA_W-1:0]     dest_d [NUM_MC];
    logic [RR_W-1:0]     rr_q, rr_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic [NUM_MC-1:0]   req;
    logic [NUM_MC-1:0]   grant_raw;
    logic [NUM_MC-1:0]   start_ok;
    logic                mc_start_e;
    logic                ldr_stall;
    logic                sb_stall;
    logic                grant_stall;
    logic                stall_any;

    // Forwarding stays combinational even during reset.
    assign ForwardAE = fwd_select(RA1E == WA3M && RegWriteM, RA1E == WA3W && RegWriteW);
    assign ForwardBE = fwd_select(RA2E == WA3M && RegWriteM, RA2E == WA3W && RegWriteW);
    assign ForwardM  = (RA2M == WA3W) && MemWriteM && MemtoRegW && RegWriteW;

    assign req = Done_MC & busy_q;

    rr_arbiter #(
        .N     (NUM_MC),
        .PTR_W (RR_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (rr_q),
        .grant_o (grant_raw)
    );

    assign WB_Grant    = Reset ? '0 : grant_raw;
    assign grant_stall = |WB_Grant;

    assign ldr_stall = ((RA1D == WA3E) || (RA2D == WA3E)) && MemtoRegE && RegWriteE;

    // A multi-cycle op just entering E has not yet marked its destination pending.
    assign mc_start_e = (|Start_MC_E) && RegWriteE;

    assign sb_stall = pending_q[RA1D] || pending_q[RA2D]
                   || (RegWriteD && pending_q[WA3D])
                   || (mc_start_e && ((RA1D == WA3E) || (RA2D == WA3E)
                                      || (RegWriteD && (WA3D == WA3E))));

    assign stall_any = !Reset && (ldr_stall || sb_stall || grant_stall);

    assign StallF = stall_any;
    assign StallD = stall_any;
    assign FlushD = !Reset && PCSrcE;
    assign FlushE = !Reset && (ldr_stall || sb_stall || PCSrcE || grant_stall);
    assign FlushM = !Reset && (|Start_MC_E);

    always_comb begin
        for (int c = 0; c < NUM_MC; c++) begin
            start_ok[c] = Start_MC_E[c] && RegWriteE && !busy_q[c] && (WA3E != PC_ADDR);
        end
    end

    // Grant clears are applied before start sets so a same-edge start wins.
    always_comb begin
        pending_d = pending_q;
        busy_d    = busy_q;
        rr_d      = rr_q;
        for (int c = 0; c < NUM_MC; c++) begin
            dest_d[c] = dest_q[c];
        end
        for (int c = 0; c < NUM_MC; c++) begin
            if (WB_Grant[c]) begin
                pending_d[dest_q[c]] = 1'b0;
                busy_d[c]            = 1'b0;
                rr_d                 = RR_W'((c + 1) % NUM_MC);
            end
        end
        for (int c = 0; c < NUM_MC; c++) begin
            if (start_ok[c]) begin
                busy_d[c]       = 1'b1;
                dest_d[c]       = WA3E;
                pending_d[WA3E] = 1'b1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (StallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            pending_q   <= '0;
            busy_q      <= '0;
            rr_q        <= '0;
            stall_cnt_q <= '0;
            for (int c = 0; c < NUM_MC; c++) begin
                dest_q[c] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            rr_q        <= rr_d;
            stall_cnt_q <= stall_cnt_d;
            for (int c = 0; c < NUM_MC; c++) begin
                dest_q[c] <= dest_d[c];
            end
        end
    end

    assign Busy_MC    = busy_q;
    assign Pending    = pending_q;
    assign StallCount = stall_cnt_q;

    // Starting a busy channel or targeting the PC is a sequencing bug upstream.
    a_start_not_busy : assert property (@(posedge CLK) disable iff (Reset)
        RegWriteE |-> ((Start_MC_E & busy_q) == '0));

    a_start_not_pc : assert property (@(posedge CLK) disable iff (Reset)
        !(mc_start_e && (WA3E == PC_ADDR)));

endmodule

// File: tb/tb_hazard_sb.sv
// Bench for hazard_sb: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a behavioural model.
module tb_hazard_sb;

    localparam int RA_W     = 4;
    localparam int NUM_REGS = 16;
    localparam int NUM_MC   = 2;
    localparam int CNT_W    = 6;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic                Reset;
    logic [RA_W-1:0]     RA1D, RA2D, WA3D, RA1E, RA2E, WA3E, WA3M, RA2M, WA3W;
    logic                RegWriteD, RegWriteE, MemtoRegE, PCSrcE;
    logic                RegWriteM, MemWriteM, RegWriteW, MemtoRegW;
    logic [NUM_MC-1:0]   Start_MC_E, Done_MC;
    logic                StallF, StallD, FlushD, FlushE, FlushM, ForwardM;
    logic [1:0]          ForwardAE, ForwardBE;
    logic [NUM_MC-1:0]   WB_Grant, Busy_MC;
    logic [NUM_REGS-1:0] Pending;
    logic [CNT_W-1:0]    StallCount;

    hazard_sb #(
        .RA_W(RA_W), .NUM_REGS(NUM_REGS), .NUM_MC(NUM_MC), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .Reset(Reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D), .RegWriteD(RegWriteD),
        .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .PCSrcE(PCSrcE),
        .Start_MC_E(Start_MC_E), .Done_MC(Done_MC),
        .WA3M(WA3M), .RA2M(RA2M), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .WA3W(WA3W), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardM(ForwardM),
        .WB_Grant(WB_Grant), .Busy_MC(Busy_MC), .Pending(Pending), .StallCount(StallCount)
    );

    int compared   = 0;
    int mismatched = 0;

    // Model state: which registers await a result, which channel owns what.
    bit m_pend [NUM_REGS];
    bit m_busy [NUM_MC];
    int m_dest [NUM_MC];
    int m_rr;
    int m_cnt;

    int  e_g;
    bit  e_stall, e_flushd, e_flushe, e_flushm, e_fwdm;
    int  e_fa, e_fb;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_eval();
        bit ldr, sb, mc;
        int a1, a2, wd, we;
        a1 = int'(RA1D); a2 = int'(RA2D); wd = int'(WA3D); we = int'(WA3E);
        e_g = -1;
        if (!Reset) begin
            for (int i = 0; i < NUM_MC; i++) begin
                int c = (m_rr + i) % NUM_MC;
                if (e_g < 0 && Done_MC[c] && m_busy[c]) e_g = c;
            end
        end
        ldr = (a1 == we || a2 == we) && MemtoRegE && RegWriteE;
        mc  = (Start_MC_E != 0) && RegWriteE;
        sb  = m_pend[a1] || m_pend[a2] || (RegWriteD && m_pend[wd])
           || (mc && (a1 == we || a2 == we || (RegWriteD && wd == we)));
        e_stall  = !Reset && (ldr || sb || e_g >= 0);
        e_flushd = !Reset && PCSrcE;
        e_flushe = !Reset && (ldr || sb || PCSrcE || e_g >= 0);
        e_flushm = !Reset && (Start_MC_E != 0);
        e_fa = (RegWriteM && RA1E == WA3M) ? 2 : (RegWriteW && RA1E == WA3W) ? 1 : 0;
        e_fb = (RegWriteM && RA2E == WA3M) ? 2 : (RegWriteW && RA2E == WA3W) ? 1 : 0;
        e_fwdm = (RA2M == WA3W) && MemWriteM && MemtoRegW && RegWriteW;
    endtask

    task automatic check_all();
        logic [NUM_REGS-1:0] ep;
        logic [NUM_MC-1:0]   eb, eg;
        model_eval();
        ep = '0; eb = '0; eg = '0;
        for (int r = 0; r < NUM_REGS; r++) ep[r] = m_pend[r];
        for (int c = 0; c < NUM_MC; c++) eb[c] = m_busy[c];
        if (e_g >= 0) eg[e_g] = 1'b1;
        chk("StallF", StallF, e_stall);
        chk("StallD", StallD, e_stall);
        chk("FlushD", FlushD, e_flushd);
        chk("FlushE", FlushE, e_flushe);
        chk("FlushM", FlushM, e_flushm);
        chk("ForwardAE", ForwardAE, e_fa);
        chk("ForwardBE", ForwardBE, e_fb);
        chk("ForwardM", ForwardM, e_fwdm);
        chk("WB_Grant", WB_Grant, eg);
        chk("Busy_MC", Busy_MC, eb);
        chk("Pending", Pending, ep);
        chk("StallCount", StallCount, m_cnt);
    endtask

    task automatic model_update();
        bit busy_old [NUM_MC];
        model_eval();
        if (Reset) begin
            for (int r = 0; r < NUM_REGS; r++) m_pend[r] = 0;
            for (int c = 0; c < NUM_MC; c++) begin m_busy[c] = 0; m_dest[c] = 0; end
            m_rr = 0; m_cnt = 0;
        end else begin
            if (e_stall && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            busy_old = m_busy;
            if (e_g >= 0) begin
                m_pend[m_dest[e_g]] = 0;
                m_busy[e_g] = 0;
                m_rr = (e_g + 1) % NUM_MC;
            end
            for (int c = 0; c < NUM_MC; c++) begin
                if (Start_MC_E[c] && RegWriteE && !busy_old[c] && WA3E != 15) begin
                    m_busy[c] = 1; m_dest[c] = int'(WA3E); m_pend[WA3E] = 1;
                end
            end
        end
    endtask

    task automatic idle();
        RA1D = 0; RA2D = 0; WA3D = 0; RegWriteD = 0;
        RA1E = 0; RA2E = 0; WA3E = 0; RegWriteE = 0; MemtoRegE = 0; PCSrcE = 0;
        Start_MC_E = 0; Done_MC = 0;
        WA3M = 0; RA2M = 0; RegWriteM = 0; MemWriteM = 0;
        WA3W = 0; RegWriteW = 0; MemtoRegW = 0;
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic advance();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        @(posedge CLK);
        model_update();
        @(negedge CLK);
        step();
        step();
        Reset = 1'b0;

        settle();
        chk("rst_pending", Pending, 16'h0);
        chk("rst_busy", Busy_MC, 2'b00);
        chk("rst_count", StallCount, 0);
        advance();

        // Forwarding from M, then from W
        RA1E = 1; WA3M = 1; RegWriteM = 1; WA3W = 1; RegWriteW = 1;
        settle();
        chk("fwdA_M", ForwardAE, 2'b10);
        chk("fwd_nostall", StallD, 1'b0);
        advance();
        RegWriteM = 0;
        settle();
        chk("fwdA_W", ForwardAE, 2'b01);
        advance();
        idle();
        RA2M = 2; WA3W = 2; MemWriteM = 1; MemtoRegW = 1; RegWriteW = 1;
        settle();
        chk("fwdM_ldr_str", ForwardM, 1'b1);
        advance();
        idle();

        // Load-use stall lasts one cycle
        WA3E = 2; RegWriteE = 1; MemtoRegE = 1; RA1D = 2;
        settle();
        chk("ldr_stallD", StallD, 1'b1);
        chk("ldr_stallF", StallF, 1'b1);
        chk("ldr_flushE", FlushE, 1'b1);
        advance();
        RegWriteE = 0; MemtoRegE = 0; WA3E = 0;
        settle();
        chk("ldr_released", StallD, 1'b0);
        chk("ldr_count", StallCount, 1);
        advance();
        idle();

        // MUL R3 on ch0; dependent ADD stalls until grant
        Start_MC_E = 2'b01; RegWriteE = 1; WA3E = 3;
        settle();
        chk("mul_flushM", FlushM, 1'b1);
        advance();
        idle();
        RA1D = 3; RegWriteD = 1; WA3D = 4;
        settle();
        chk("mul_pend3", Pending[3], 1'b1);
        chk("mul_busy", Busy_MC, 2'b01);
        chk("mul_dep_stall", StallD, 1'b1);
        advance();
        step();
        Done_MC = 2'b01;
        settle();
        chk("mul_grant", WB_Grant, 2'b01);
        advance();
        Done_MC = 2'b00;
        settle();
        chk("mul_pend3_clr", Pending[3], 1'b0);
        chk("mul_dep_go", StallD, 1'b0);
        advance();
        idle();

        // Move rr back to 0 via a ch1 grant, then two simultaneous dones
        Start_MC_E = 2'b10; RegWriteE = 1; WA3E = 8;
        step();
        idle();
        Done_MC = 2'b10;
        settle();
        chk("ch1_grant", WB_Grant, 2'b10);
        advance();
        idle();
        Start_MC_E = 2'b01; RegWriteE = 1; WA3E = 6;
        step();
        Start_MC_E = 2'b10; WA3E = 7;
        step();
        idle();
        Done_MC = 2'b11;
        settle();
        chk("rr_first", WB_Grant, 2'b01);
        chk("rr_first_flushE", FlushE, 1'b1);
        advance();
        settle();
        chk("rr_second", WB_Grant, 2'b10);
        chk("rr_second_flushE", FlushE, 1'b1);
        advance();
        idle();

        // Grant of ch1 (R5) and start of ch0 to R5 on one edge: set wins
        Start_MC_E = 2'b10; RegWriteE = 1; WA3E = 5;
        step();
        idle();
        Done_MC = 2'b10; Start_MC_E = 2'b01; RegWriteE = 1; WA3E = 5;
        settle();
        chk("same_edge_grant", WB_Grant, 2'b10);
        advance();
        idle();
        settle();
        chk("same_edge_pend5", Pending[5], 1'b1);
        chk("same_edge_busy", Busy_MC, 2'b01);
        advance();
        Start_MC_E = 2'b10; RegWriteE = 1; WA3E = 9;
        step();
        idle();
        Done_MC = 2'b11;
        settle();
        chk("rr_back_to0", WB_Grant, 2'b01);
        advance();
        Done_MC = 2'b10;
        step();
        idle();
        step();

        // Reset in the middle of a MUL
        Start_MC_E = 2'b01; RegWriteE = 1; WA3E = 3;
        step();
        idle();
        settle();
        chk("pre_rst_busy", Busy_MC, 2'b01);
        chk("pre_rst_pend3", Pending[3], 1'b1);
        advance();
        Reset = 1'b1;
        settle();
        chk("in_rst_grant", WB_Grant, 2'b00);
        advance();
        Reset = 1'b0;
        settle();
        chk("post_rst_pending", Pending, 16'h0);
        chk("post_rst_busy", Busy_MC, 2'b00);
        chk("post_rst_count", StallCount, 0);
        advance();
        Done_MC = 2'b01;
        settle();
        chk("post_rst_no_grant", WB_Grant, 2'b00);
        advance();
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            Reset      = ($urandom_range(0, 199) == 0);
            RA1D       = RA_W'($urandom_range(0, 15));
            RA2D       = RA_W'($urandom_range(0, 15));
            WA3D       = RA_W'($urandom_range(0, 15));
            RegWriteD  = 1'($urandom_range(0, 1));
            RA1E       = RA_W'($urandom_range(0, 15));
            RA2E       = RA_W'($urandom_range(0, 15));
            WA3E       = RA_W'($urandom_range(0, 15));
            RegWriteE  = 1'($urandom_range(0, 1));
            MemtoRegE  = ($urandom_range(0, 3) == 0);
            PCSrcE     = ($urandom_range(0, 7) == 0);
            WA3M       = RA_W'($urandom_range(0, 15));
            RA2M       = RA_W'($urandom_range(0, 15));
            RegWriteM  = 1'($urandom_range(0, 1));
            MemWriteM  = 1'($urandom_range(0, 1));
            WA3W       = RA_W'($urandom_range(0, 15));
            RegWriteW  = 1'($urandom_range(0, 1));
            MemtoRegW  = 1'($urandom_range(0, 1));
            Start_MC_E = '0;
            if ($urandom_range(0, 2) == 0) begin
                int c = $urandom_range(0, NUM_MC - 1);
                if (!m_busy[c]) begin
                    Start_MC_E[c] = 1'b1;
                    WA3E = RA_W'($urandom_range(0, 14));
                end
            end
            for (int c = 0; c < NUM_MC; c++) begin
                Done_MC[c] = (m_busy[c] && $urandom_range(0, 2) == 0)
                          || ($urandom_range(0, 15) == 0);
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_sb.md
Name: hazard_sb

Overview:
Parametrised hazard unit for the 5-stage ARM pipeline that replaces the fixed single-MCycle stall logic with a register scoreboard.
- Supports NUM_MC independent multi-cycle units (MUL, DIV, ...) with out-of-order completion.
- Arbitrates their write-back slots round-robin.
- Keeps DP/LDR forwarding, load-use stall and branch flush.
- Sits beside the datapath; all stage registers take their stall/flush controls from it.

Parameters:
- RA_W, 4, register address width.
- NUM_REGS, 16, architectural registers tracked (2**RA_W).
- NUM_MC, 2, number of multi-cycle channels (1..8).
- CNT_W, 32, width of the stall performance counter.

Ports:
- CLK  in  1  clock, rising edge.
- Reset  in  1  synchronous, active-high.
- RA1D, RA2D, WA3D  in  RA_W each  decode read/write addresses.
- RegWriteD  in  1  decode instruction writes WA3D.
- RA1E, RA2E, WA3E  in  RA_W each  execute addresses.
- RegWriteE, MemtoRegE, PCSrcE  in  1 each  execute controls (already condition-qualified).
- Start_MC_E  in  NUM_MC  one-hot start of a multi-cycle op in E; its destination is WA3E.
- Done_MC  in  NUM_MC  level; channel c holds its result until granted.
- WA3M, RA2M  in  RA_W each; RegWriteM, MemWriteM  in  1 each.
- WA3W  in  RA_W; RegWriteW, MemtoRegW  in  1 each.
- StallF, StallD, FlushD, FlushE, FlushM  out  1 each.
- ForwardAE, ForwardBE  out  2 each  00 RF, 01 W, 10 M.
- ForwardM  out  1  LDR->STR forward.
- WB_Grant  out  NUM_MC  one-hot write-back grant.
- Busy_MC  out  NUM_MC  channel owns an outstanding destination.
- Pending  out  NUM_REGS  scoreboard bits.
- StallCount  out  CNT_W  cycles with StallD=1.

Behaviour:
- State: Pending[NUM_REGS], per channel Busy_MC[c] and DestReg[c] (RA_W), round-robin pointer rr (log2 NUM_MC), StallCount.
- Reset: all state 0. While Reset=1, WB_Grant=0 and all stalls/flushes=0. Forward outputs stay purely combinational.
- Forwarding: identical priority to the existing unit.
  - ForwardAE/BE = 10 if RAxE==WA3M & RegWriteM; else 01 if RAxE==WA3W & RegWriteW; else 00.
  - ForwardM = RA2M==WA3W & MemWriteM & MemtoRegW & RegWriteW.
- LDRstall = (RA1D==WA3E | RA2D==WA3E) & MemtoRegE & RegWriteE.
- SBstall = any of RA1D, RA2D, or WA3D (when RegWriteD) has Pending=1, or equals WA3E while |Start_MC_E & RegWriteE.
  - The WA3D check prevents WAW reordering.
- Grant:
  - Among channels with Done_MC & Busy_MC, pick the first at or after rr (wrap-around). At most one grant per cycle.
  - On a grant edge: Pending[DestReg[g]] cleared, Busy_MC[g] cleared, rr <= g+1 mod NUM_MC.
  - GrantStall = |WB_Grant. The top level muxes the granted result into the M stage on the next edge.
- Start: on an edge with Start_MC_E[c] & RegWriteE & !Busy_MC[c] & WA3E!=15:
  - Busy_MC[c] <= 1, DestReg[c] <= WA3E, Pending[WA3E] <= 1.
  - Start on an already-busy channel or to R15 is ignored (SVA error).
- Same-edge grant-clear and start-set on one register: set wins.
- StallF = StallD = LDRstall | SBstall | GrantStall.
- FlushD = PCSrcE.
- FlushE = LDRstall | SBstall | PCSrcE | GrantStall.
- FlushM = |Start_MC_E (bubble while the unit computes).
- StallCount increments when StallD=1 and saturates at all-ones.
- Done_MC on a non-busy channel is ignored.

Decomposition:
- Package hazard_pkg: forward-select encodings (FWD_RF, FWD_W, FWD_M) and PC register index (15).
- One sub-module, rr_arbiter (parameter N): request vector + pointer in, one-hot grant out, purely combinational. Pointer register lives in hazard_sb.

Test Plan:
- ADD R1 in M, SUB reads R1 in E -> ForwardAE=10; R1 in W only -> 01; no stall.
- LDR R2 in E, decode reads R2 -> StallF=StallD=FlushE=1 for exactly 1 cycle; StallCount=1.
- MUL R3 starts on ch0 -> FlushM=1 that cycle, Pending[3]=1. Decode ADD R4,R3 stalls until ch0 granted; Pending[3]=0 the following cycle.
- NUM_MC=2, Done_MC=11 with rr=0 -> WB_Grant=01 then 10 on consecutive cycles, each with FlushE=1; rr ends at 0.
- Grant of ch1 (R5) and start of ch0 to R5 on the same edge -> Pending[5]=1, Busy_MC=01.
- Reset asserted mid-MUL (Busy_MC=01, Pending[3]=1) -> next edge Pending=0, Busy_MC=0, StallCount=0; a later Done_MC[0] produces no grant.
